// File: rtl/exc_ctrl.sv
// CP0 exception/interrupt controller.
// Prioritises hardware interrupts and execute-stage exceptions, then sequences
// exception entry and ERET return by driving the Cause/EPC/Status write ports,
// the pipeline flush and the PC redirect. All outputs come straight from flops.
module exc_ctrl #(
  parameter logic [31:0] HANDLER_PC = 32'h0000_4180,
  parameter int unsigned NUM_INT    = 6
) (
  input  logic               clk,
  input  logic               rst,
  input  logic [NUM_INT-1:0] hw_int,
  input  logic               inst_valid,
  input  logic [31:0]        pc_in,
  input  logic               bd,
  input  logic               exc_ri,
  input  logic               exc_sys,
  input  logic               exc_ov,
  input  logic               eret,
  input  logic [31:0]        status_q,
  input  logic [31:0]        cause_q,
  input  logic [31:0]        epc_q,
  output logic               cause_w,
  output logic [31:0]        cause_d,
  output logic               epc_w,
  output logic [31:0]        epc_d,
  output logic               status_w,
  output logic [31:0]        status_d,
  output logic               flush,
  output logic               redirect,
  output logic [31:0]        redirect_pc,
  output logic               busy
);

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    ENTRY  = 2'd1,
    RETURN = 2'd2
  } state_t;

  state_t state, state_next;

  logic [NUM_INT-1:0] int_meta;
  logic [NUM_INT-1:0] ip_sync;
  logic [5:0]         ip_field;

  logic        exl;
  logic        ie;
  logic        int_req;
  logic        exc_any;
  logic        accept;
  logic        ret;
  logic        refresh;
  logic [4:0]  exc_code;
  logic [31:0] epc_cap;

  logic        cause_w_n;
  logic [31:0] cause_d_n;
  logic        epc_w_n;
  logic [31:0] epc_d_n;
  logic        status_w_n;
  logic [31:0] status_d_n;
  logic        flush_n;
  logic        redirect_n;
  logic [31:0] redirect_pc_n;
  logic        busy_n;

  // Two-flop synchroniser for the asynchronous interrupt lines.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      int_meta <= '0;
      ip_sync  <= '0;
    end else begin
      int_meta <= hw_int;
      ip_sync  <= int_meta;
    end
  end

  // Zero-extend the synchronised lines into the 6-bit IP field of Cause.
  always_comb begin
    ip_field = '0;
    ip_field[NUM_INT-1:0] = ip_sync;
  end

  // Request decode: interrupt qualification, priority encoding and EPC selection.
  always_comb begin
    exl     = status_q[1];
    ie      = status_q[0];
    int_req = ie & ~exl & (|(ip_sync & status_q[10 +: NUM_INT]));
    exc_any = ~exl & (int_req | exc_ri | exc_sys | exc_ov);
    accept  = (state == IDLE) & inst_valid & exc_any;
    ret     = (state == IDLE) & inst_valid & ~exc_any & eret & exl;
    // cause_w being high means a refresh is already in flight and cause_q is
    // still stale for one cycle; holding off here keeps it to a single pulse.
    refresh = (state == IDLE) & ~accept & ~ret & ~cause_w &
              (ip_field != cause_q[15:10]);

    if (int_req)      exc_code = 5'd0;
    else if (exc_ri)  exc_code = 5'd10;
    else if (exc_sys) exc_code = 5'd8;
    else              exc_code = 5'd12;

    epc_cap = bd ? (pc_in - 32'd4) : pc_in;
  end

  // State and output registers; outputs are loaded from the next-state decode
  // so they line up with the cycle the FSM spends in ENTRY/RETURN.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state       <= IDLE;
      cause_w     <= 1'b0;
      cause_d     <= '0;
      epc_w       <= 1'b0;
      epc_d       <= '0;
      status_w    <= 1'b0;
      status_d    <= '0;
      flush       <= 1'b0;
      redirect    <= 1'b0;
      redirect_pc <= '0;
      busy        <= 1'b0;
    end else begin
      state       <= state_next;
      cause_w     <= cause_w_n;
      cause_d     <= cause_d_n;
      epc_w       <= epc_w_n;
      epc_d       <= epc_d_n;
      status_w    <= status_w_n;
      status_d    <= status_d_n;
      flush       <= flush_n;
      redirect    <= redirect_n;
      redirect_pc <= redirect_pc_n;
      busy        <= busy_n;
    end
  end

  // Next-state logic: ENTRY and RETURN each last one cycle.
  always_comb begin
    state_next = IDLE;
    case (state)
      IDLE: begin
        if (accept)   state_next = ENTRY;
        else if (ret) state_next = RETURN;
        else          state_next = IDLE;
      end
      default: state_next = IDLE;
    endcase
  end

  // Output decode for the upcoming cycle, including the IP refresh write.
  always_comb begin
    cause_w_n     = 1'b0;
    cause_d_n     = '0;
    epc_w_n       = 1'b0;
    epc_d_n       = '0;
    status_w_n    = 1'b0;
    status_d_n    = '0;
    flush_n       = 1'b0;
    redirect_n    = 1'b0;
    redirect_pc_n = '0;
    busy_n        = 1'b0;
    case (state_next)
      ENTRY: begin
        cause_w_n     = 1'b1;
        cause_d_n     = {bd, cause_q[30:16], ip_field, cause_q[9:7], exc_code, 2'b00};
        epc_w_n       = 1'b1;
        epc_d_n       = epc_cap;
        status_w_n    = 1'b1;
        status_d_n    = status_q | 32'h0000_0002;
        flush_n       = 1'b1;
        redirect_n    = 1'b1;
        redirect_pc_n = HANDLER_PC;
        busy_n        = 1'b1;
      end
      RETURN: begin
        status_w_n    = 1'b1;
        status_d_n    = status_q & ~32'h0000_0002;
        flush_n       = 1'b1;
        redirect_n    = 1'b1;
        redirect_pc_n = epc_q;
        busy_n        = 1'b1;
      end
      default: begin
        if (refresh) begin
          cause_w_n = 1'b1;
          cause_d_n = {cause_q[31:16], ip_field, cause_q[9:0]};
        end
      end
    endcase
  end

endmodule
